phase_step_sweep: RTL and testbench
===================================

PHASE_STEP_SWEEP -- requirements
Module: phase_step_sweep

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32: width of all phase-step values.
REQ-002 SHALL have parameter DWELL_WIDTH, default 24: width of the dwell count.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1: sweep start request, sampled in IDLE only.
REQ-006 SHALL have port i_abort, input, 1: terminate the sweep immediately.
REQ-007 SHALL have port i_start_step, input, PHASE_WIDTH: first phase step, unsigned.
REQ-008 SHALL have port i_stop_step, input, PHASE_WIDTH: upper bound of the sweep, unsigned, inclusive.
REQ-009 SHALL have port i_step_inc, input, PHASE_WIDTH: increment between steps, unsigned.
REQ-010 SHALL have port i_dwell, input, DWELL_WIDTH: clock cycles each step is held.
REQ-011 SHALL have port o_phase_step, output, PHASE_WIDTH: registered value driving the sine generator's i_phase_step.
REQ-012 SHALL have port o_step_stb, output, 1: one-cycle pulse in the first cycle of each new o_phase_step value.
REQ-013 SHALL have port o_busy, output, 1: high while a sweep is in progress.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse on normal sweep completion.

Function
REQ-015 SHALL implement states IDLE and DWELL only.
REQ-016 SHALL latch i_start_step, i_stop_step, i_step_inc and i_dwell on start; later input changes have no effect until the next start.
REQ-017 SHALL, when i_start=1 in IDLE at cycle N, show o_phase_step=i_start_step, o_step_stb=1 and o_busy=1 at cycle N+1, then enter DWELL.
REQ-018 SHALL hold each step for exactly D cycles, where D=i_dwell, except that i_dwell=0 is treated as D=1.
REQ-019 SHALL, at the end of a dwell, compute next = current + inc in PHASE_WIDTH+1 bits.
REQ-020 SHALL, if next <= stop and no carry occurred, load next in the following cycle, pulse o_step_stb and restart the dwell.
REQ-021 SHALL otherwise, in the following cycle, drive o_done=1 and o_busy=0, return to IDLE, and hold o_phase_step at its last value.
REQ-022 SHALL emit exactly one step when i_step_inc=0 or i_start_step>i_stop_step, followed by o_done.
REQ-023 SHALL include i_stop_step as a step whenever the sweep lands on it exactly.
REQ-024 SHALL, on i_abort=1 in any state, next cycle be in IDLE with o_busy=0, o_phase_step=0, o_step_stb=0 and o_done=0 (no done pulse).
REQ-025 SHALL give i_abort priority over i_start when both are high in the same cycle.
REQ-026 SHALL ignore i_start while in DWELL.
REQ-027 SHALL accept i_start in the o_done pulse cycle, because the block is already in IDLE then.

Reset
REQ-028 SHALL, on i_rst=1 at a clock edge, force IDLE with o_phase_step=0, o_step_stb=0, o_busy=0, o_done=0 and the dwell counter at 0.
REQ-029 SHALL give reset priority over i_abort and i_start, including mid-sweep.

Configuration
REQ-030 SHALL, with macro SWEEP_WRAP_EN defined, add input port i_wrap (1 bit), latched at start.
REQ-031 SHALL, when i_wrap was latched high, replace end-of-sweep with reload of i_start_step plus an o_step_stb pulse, keep o_busy=1, pulse o_done once per wrap, and run until abort or reset.
REQ-032 SHALL, without SWEEP_WRAP_EN, omit the i_wrap port and always terminate as in REQ-021.

Verification
REQ-033 SHALL cover basic sweep: start=0, stop=3000, inc=1000, dwell=4 -> steps 0, 1000, 2000, 3000, each held 4 cycles, 4 stb pulses, o_done 17 cycles after start.
REQ-034 SHALL cover non-aligned stop: start=100, stop=250, inc=100, dwell=2 -> steps 100, 200 only, then o_done.
REQ-035 SHALL cover overflow: start=0xFFFFFF00, stop=0xFFFFFFFF, inc=0x80, dwell=1 -> steps 0xFFFFFF00, 0xFFFFFF80, then o_done, with no wrap to a small value.
REQ-036 SHALL cover degenerate inputs: inc=0 or start=500 with stop=100, dwell=0 -> single step held 1 cycle, then o_done.
REQ-037 SHALL cover abort and reset: i_abort at the 2nd dwell cycle of step 2 -> next cycle o_phase_step=0, o_busy=0, no o_done; repeat with i_rst giving the same result.
REQ-038 SHALL cover wrap (SWEEP_WRAP_EN): start=0, stop=2000, inc=1000, dwell=3, i_wrap=1 -> sequence 0, 1000, 2000, 0, ... with o_done every 9 cycles and o_busy held high.

Source files
------------

// File: rtl/phase_step_sweep.sv
// Phase-step sweep sequencer for a sine generator.
// Walks o_phase_step from a start value up to an inclusive stop value in
// fixed increments, holding each value for a programmable number of cycles.
// Optional feature: define SWEEP_WRAP_EN to add the i_wrap input, which makes
// the sweep restart from the start value instead of finishing.
module phase_step_sweep #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [PHASE_WIDTH-1:0] i_start_step,
  input  logic [PHASE_WIDTH-1:0] i_stop_step,
  input  logic [PHASE_WIDTH-1:0] i_step_inc,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
`ifdef SWEEP_WRAP_EN
  input  logic                   i_wrap,
`endif
  output logic [PHASE_WIDTH-1:0] o_phase_step,
  output logic                   o_step_stb,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [PHASE_WIDTH-1:0] phase_reg, phase_next;
  logic [DWELL_WIDTH-1:0] cnt_reg, cnt_next;
  logic                   stb_reg, stb_next;
  logic                   done_reg, done_next;

  // Sweep configuration captured at start
  logic [PHASE_WIDTH-1:0] start_step_reg;
  logic [PHASE_WIDTH-1:0] stop_step_reg;
  logic [PHASE_WIDTH-1:0] step_inc_reg;
  logic [DWELL_WIDTH-1:0] dwell_m1_reg;
  logic                   load_cfg;
  logic                   wrap_en;

  // Dwell counter counts down from D-1; a dwell of 0 behaves like 1
  logic [DWELL_WIDTH-1:0] dwell_m1_in;
  assign dwell_m1_in = (i_dwell == '0) ? '0 : i_dwell - DWELL_WIDTH'(1);

  // One extra bit catches the carry out of the phase addition
  logic [PHASE_WIDTH:0] step_sum;
  logic                 advance;
  assign step_sum = {1'b0, phase_reg} + {1'b0, step_inc_reg};
  assign advance  = (step_inc_reg != '0) && !step_sum[PHASE_WIDTH]
                    && (step_sum[PHASE_WIDTH-1:0] <= stop_step_reg);

  // State, datapath and configuration registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      cnt_reg        <= '0;
      stb_reg        <= 1'b0;
      done_reg       <= 1'b0;
      start_step_reg <= '0;
      stop_step_reg  <= '0;
      step_inc_reg   <= '0;
      dwell_m1_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      stb_reg   <= stb_next;
      done_reg  <= done_next;
      if (load_cfg) begin
        start_step_reg <= i_start_step;
        stop_step_reg  <= i_stop_step;
        step_inc_reg   <= i_step_inc;
        dwell_m1_reg   <= dwell_m1_in;
      end
    end
  end

`ifdef SWEEP_WRAP_EN
  logic wrap_reg;

  // Wrap mode is captured together with the rest of the configuration
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrap_reg <= 1'b0;
    end else if (load_cfg) begin
      wrap_reg <= i_wrap;
    end
  end

  assign wrap_en = wrap_reg;
`else
  assign wrap_en = 1'b0;
`endif

  // Next-state and next-datapath logic; abort overrides everything else
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    stb_next   = 1'b0;
    done_next  = 1'b0;
    load_cfg   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          load_cfg   = 1'b1;
          state_next = DWELL;
          phase_next = i_start_step;
          cnt_next   = dwell_m1_in;
          stb_next   = 1'b1;
        end
      end
      DWELL: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DWELL_WIDTH'(1);
        end else if (advance) begin
          phase_next = step_sum[PHASE_WIDTH-1:0];
          cnt_next   = dwell_m1_reg;
          stb_next   = 1'b1;
        end else if (wrap_en) begin
          phase_next = start_step_reg;
          cnt_next   = dwell_m1_reg;
          stb_next   = 1'b1;
          done_next  = 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (i_abort) begin
      state_next = IDLE;
      phase_next = '0;
      cnt_next   = '0;
      stb_next   = 1'b0;
      done_next  = 1'b0;
      load_cfg   = 1'b0;
    end
  end

  // Outputs come straight from registers; busy is the DWELL state
  always_comb begin
    o_phase_step = phase_reg;
    o_step_stb   = stb_reg;
    o_done       = done_reg;
    o_busy       = (state_reg == DWELL);
  end

endmodule

// File: tb/tb_phase_step_sweep.sv
// Self-checking bench for phase_step_sweep: directed vector table, hand-written
// abort/reset/back-to-back sequences and randomized sweeps against a model.
module tb_phase_step_sweep;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_abort;
  logic [31:0] i_start_step, i_stop_step, i_step_inc;
  logic [23:0] i_dwell;
`ifdef SWEEP_WRAP_EN
  logic        i_wrap;
`endif
  logic [31:0] o_phase_step;
  logic        o_step_stb, o_busy, o_done;

  int errors = 0;
  int checks = 0;

  phase_step_sweep #(.PHASE_WIDTH(32), .DWELL_WIDTH(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_start_step(i_start_step), .i_stop_step(i_stop_step),
    .i_step_inc(i_step_inc), .i_dwell(i_dwell),
`ifdef SWEEP_WRAP_EN
    .i_wrap(i_wrap),
`endif
    .o_phase_step(o_phase_step), .o_step_stb(o_step_stb),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] s;
    logic [31:0] p;
    logic [31:0] inc;
    logic [23:0] dw;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] pack_out();
    return {o_phase_step, o_step_stb, o_busy, o_done};
  endfunction

  // Reference: list of step values, computed with wide arithmetic
  task automatic build_steps(input logic [31:0] s, input logic [31:0] p, input logic [31:0] inc);
    longint unsigned cur, nxt;
    exp_q.delete();
    cur = s;
    exp_q.push_back(s);
    if (inc != 0) begin
      for (int i = 0; i < 1000; i++) begin
        nxt = cur + longint'(inc);
        if (nxt > longint'(p)) break;
        exp_q.push_back(nxt[31:0]);
        cur = nxt;
      end
    end
  endtask

  // Runs one complete sweep starting at a negedge; checks every cycle
  task automatic run_sweep(input logic [31:0] s, input logic [31:0] p, input logic [31:0] inc,
                           input logic [23:0] dw, output int nstb, output logic [31:0] last);
    int d, total;
    build_steps(s, p, inc);
    d = (dw == 0) ? 1 : int'(dw);
    total = exp_q.size() * d;
    i_start_step = s; i_stop_step = p; i_step_inc = inc; i_dwell = dw; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_start_step = $urandom; i_stop_step = $urandom; i_step_inc = $urandom;
    i_dwell = 24'($urandom);
    nstb = 0;
    last = '0;
    for (int k = 0; k < total; k++) begin
      check("sweep", 64'(pack_out()), 64'({exp_q[k / d], (k % d) == 0, 1'b1, 1'b0}));
      if (o_step_stb) begin
        nstb++;
        last = o_phase_step;
      end
      i_start = 1'($urandom_range(0, 1));
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check("done", 64'(pack_out()), 64'({exp_q[exp_q.size() - 1], 1'b0, 1'b0, 1'b1}));
    @(negedge i_clk);
    check("idle", 64'(pack_out()), 64'({exp_q[exp_q.size() - 1], 1'b0, 1'b0, 1'b0}));
    $display("sweep start=%h stop=%h inc=%h dwell=%0d steps=%0d", s, p, inc, dw, nstb);
  endtask

  initial begin
    int          nstb;
    logic [31:0] last;
    logic [31:0] rs, rinc, rp;
    longint unsigned lp;

    vecs[0] = '{32'd0,          32'd3000,     32'd1000, 24'd4, 4, 32'd3000};
    vecs[1] = '{32'd100,        32'd250,      32'd100,  24'd2, 2, 32'd200};
    vecs[2] = '{32'hFFFFFF00,   32'hFFFFFFFF, 32'h80,   24'd1, 2, 32'hFFFFFF80};
    vecs[3] = '{32'h10,         32'h1000,     32'd0,    24'd0, 1, 32'h10};
    vecs[4] = '{32'd500,        32'd100,      32'd7,    24'd0, 1, 32'd500};
    vecs[5] = '{32'd42,         32'd42,       32'd5,    24'd3, 1, 32'd42};
    vecs[6] = '{32'hFFFFFF00,   32'hFFFFFFFF, 32'hFF,   24'd2, 2, 32'hFFFFFFFF};
    vecs[7] = '{32'd10,         32'd30,       32'd10,   24'd1, 3, 32'd30};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_start_step = '0; i_stop_step = '0; i_step_inc = '0; i_dwell = '0;
`ifdef SWEEP_WRAP_EN
    i_wrap = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    check("reset", 64'(pack_out()), 64'd0);
    $display("reset outputs=%h", pack_out());
    i_rst = 1'b0;
    @(negedge i_clk);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      run_sweep(vecs[v].s, vecs[v].p, vecs[v].inc, vecs[v].dw, nstb, last);
      check("tbl_nsteps", 64'(nstb), 64'(vecs[v].exp_n));
      check("tbl_last", 64'(last), 64'(vecs[v].exp_last));
    end

    // Start accepted in the done-pulse cycle
    i_start_step = 32'd10; i_stop_step = 32'd20; i_step_inc = 32'd10; i_dwell = 24'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("b2b_s1", 64'(pack_out()), 64'({32'd10, 1'b1, 1'b1, 1'b0}));
    @(negedge i_clk);
    check("b2b_s2", 64'(pack_out()), 64'({32'd20, 1'b1, 1'b1, 1'b0}));
    @(negedge i_clk);
    check("b2b_done", 64'(pack_out()), 64'({32'd20, 1'b0, 1'b0, 1'b1}));
    i_start_step = 32'd77; i_stop_step = 32'd77; i_step_inc = 32'd1; i_dwell = 24'd2;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("b2b_new", 64'(pack_out()), 64'({32'd77, 1'b1, 1'b1, 1'b0}));
    @(negedge i_clk);
    check("b2b_hold", 64'(pack_out()), 64'({32'd77, 1'b0, 1'b1, 1'b0}));
    @(negedge i_clk);
    check("b2b_done2", 64'(pack_out()), 64'({32'd77, 1'b0, 1'b0, 1'b1}));
    @(negedge i_clk);
    $display("back-to-back start sequence done");

    // Abort wins over start in IDLE
    i_start_step = 32'd5; i_stop_step = 32'd50; i_step_inc = 32'd5; i_dwell = 24'd2;
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_prio", 64'(pack_out()), 64'd0);
    $display("abort+start priority outputs=%h", pack_out());

    // Abort and then reset at the 2nd dwell cycle of step 2
    for (int pass = 0; pass < 2; pass++) begin
      i_start_step = 32'd0; i_stop_step = 32'd3000; i_step_inc = 32'd1000; i_dwell = 24'd4;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (5) @(negedge i_clk);
      check("pre_abort", 64'(pack_out()), 64'({32'd1000, 1'b0, 1'b1, 1'b0}));
      if (pass == 0) i_abort = 1'b1;
      else begin
        i_rst = 1'b1; i_abort = 1'b1; i_start = 1'b1;
      end
      @(negedge i_clk);
      i_abort = 1'b0; i_rst = 1'b0; i_start = 1'b0;
      check(pass == 0 ? "abort" : "rst_mid", 64'(pack_out()), 64'd0);
      for (int k = 0; k < 20; k++) begin
        @(negedge i_clk);
        check("post_abort", 64'(pack_out()), 64'd0);
      end
      $display("%s mid-sweep: outputs=%h", pass == 0 ? "abort" : "reset", pack_out());
    end

`ifdef SWEEP_WRAP_EN
    // Wrap mode: 0,1000,2000 repeating, done on every reload
    i_start_step = 32'd0; i_stop_step = 32'd2000; i_step_inc = 32'd1000; i_dwell = 24'd3;
    i_wrap = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_wrap = 1'b0;
    for (int k = 0; k < 27; k++) begin
      check("wrap", 64'(pack_out()),
            64'({32'(((k / 3) % 3) * 1000), (k % 3) == 0, 1'b1, (k % 9 == 0) && (k > 0)}));
      @(negedge i_clk);
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("wrap_abort", 64'(pack_out()), 64'd0);
    $display("wrap sequence done");
`endif

    // Randomized sweeps against the model
    for (int r = 0; r < 25; r++) begin
      rs   = $urandom;
      rinc = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
      lp   = longint'(rs) + longint'($urandom_range(0, 6)) * longint'(rinc)
             + longint'($urandom_range(0, 1000));
      if ($urandom_range(0, 9) == 0) lp = longint'($urandom);
      rp   = (lp > 64'hFFFFFFFF) ? 32'hFFFFFFFF : lp[31:0];
      run_sweep(rs, rp, rinc, 24'($urandom_range(0, 5)), nstb, last);
      check("rnd_nsteps", 64'(nstb), 64'(exp_q.size()));
      check("rnd_last", 64'(last), 64'(exp_q[exp_q.size() - 1]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
